// File: rtl/uart_pkg.sv
// UART shared definitions: receive FSM state encoding and oversampling constants.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_e;

    localparam int OVERSAMPLE = 16;  // ticks per bit
    localparam int MID_SAMPLE = 7;   // s_cnt value at the middle of the start bit

endpackage

// File: rtl/uart_rx_core_if.sv
// Receive-side result bundle from uart_rx_core to the RX FIFO / status logic.
interface uart_rx_core_if #(parameter int DBIT = 8);

    logic [DBIT-1:0] rx_dout;
    logic            rx_done_tick;
    logic            frame_err;
    logic            parity_err;
    logic            busy;

    modport master (output rx_dout, rx_done_tick, frame_err, parity_err, busy);
    modport slave  (input  rx_dout, rx_done_tick, frame_err, parity_err, busy);

endinterface

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator: one tick every divsr+1 clk.
// The >= compare lets a smaller divsr take effect at once without a counter wrap.
module uart_baud_gen #(
    parameter int DIVSR_W = 10
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic [DIVSR_W-1:0] divsr,
    output logic               tick
);

    logic [DIVSR_W-1:0] r_cnt;
    logic               w_tick;

    assign w_tick = (r_cnt >= divsr);
    assign tick   = w_tick;

    // Count every clk, restart on tick.
    always_ff @(posedge clk) begin
        if (Reset)       r_cnt <= '0;
        else if (w_tick) r_cnt <= '0;
        else             r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive core: 2-flop synchroniser, 16x oversampling, 8N1 deframing.
// Optional even-parity bit after the data bits when UART_RX_PARITY_EN is defined;
// without it parity_err is tied low and the frame has no parity slot.
module uart_rx_core #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DIVSR_W = 10
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic [DIVSR_W-1:0] divsr,
    input  logic               rx,
    uart_rx_core_if.master     rx_if
);

    import uart_pkg::*;

    logic [1:0]      r_sync;
    uart_rx_state_e  r_state,  w_state_n;
    logic [4:0]      r_s_cnt,  w_s_cnt_n;
    logic [2:0]      r_n_cnt,  w_n_cnt_n;
    logic [DBIT-1:0] r_shreg,  w_shreg_n;
    logic [DBIT-1:0] r_dout,   w_dout_n;
    logic            r_done,   w_done_n;
    logic            r_ferr,   w_ferr_n;
`ifdef UART_RX_PARITY_EN
    logic            r_par,    w_par_n;
    logic            r_perr,   w_perr_n;
`endif
    logic            w_rx_s;
    logic            w_tick;

    uart_baud_gen #(.DIVSR_W(DIVSR_W)) u_baud (
        .clk   (clk),
        .Reset (Reset),
        .divsr (divsr),
        .tick  (w_tick)
    );

    assign w_rx_s = r_sync[1];

    // Bring the asynchronous line into the clk domain; idle-high on reset.
    always_ff @(posedge clk) begin
        if (Reset) r_sync <= 2'b11;
        else       r_sync <= {r_sync[0], rx};
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_s_cnt <= '0;
            r_n_cnt <= '0;
            r_shreg <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_n;
            r_s_cnt <= w_s_cnt_n;
            r_n_cnt <= w_n_cnt_n;
            r_shreg <= w_shreg_n;
            r_dout  <= w_dout_n;
            r_done  <= w_done_n;
            r_ferr  <= w_ferr_n;
`ifdef UART_RX_PARITY_EN
            r_par   <= w_par_n;
            r_perr  <= w_perr_n;
`endif
        end
    end

    // Next-state and frame result logic; counters advance only on ticks
    // except the IDLE start-edge detect, which runs every clk.
    always_comb begin
        w_state_n = r_state;
        w_s_cnt_n = r_s_cnt;
        w_n_cnt_n = r_n_cnt;
        w_shreg_n = r_shreg;
        w_dout_n  = r_dout;
        w_done_n  = 1'b0;
        w_ferr_n  = r_ferr;
`ifdef UART_RX_PARITY_EN
        w_par_n   = r_par;
        w_perr_n  = r_perr;
`endif
        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_n = START;
                    w_s_cnt_n = '0;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_s_cnt == 5'(MID_SAMPLE)) begin
                        if (!w_rx_s) begin
                            w_state_n = DATA;
                            w_s_cnt_n = '0;
                            w_n_cnt_n = '0;
                        end else begin
                            w_state_n = IDLE;  // start-bit glitch
                        end
                    end else begin
                        w_s_cnt_n = r_s_cnt + 5'd1;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_s_cnt == 5'(OVERSAMPLE-1)) begin
                        w_s_cnt_n = '0;
                        w_shreg_n = {w_rx_s, r_shreg[DBIT-1:1]};
                        if (r_n_cnt == 3'(DBIT-1)) begin
`ifdef UART_RX_PARITY_EN
                            w_state_n = PARITY;
`else
                            w_state_n = STOP;
`endif
                        end else begin
                            w_n_cnt_n = r_n_cnt + 3'd1;
                        end
                    end else begin
                        w_s_cnt_n = r_s_cnt + 5'd1;
                    end
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (w_tick) begin
                    if (r_s_cnt == 5'(OVERSAMPLE-1)) begin
                        w_s_cnt_n = '0;
                        w_par_n   = w_rx_s;
                        w_state_n = STOP;
                    end else begin
                        w_s_cnt_n = r_s_cnt + 5'd1;
                    end
                end
`else
                w_state_n = IDLE;
`endif
            end
            STOP: begin
                if (w_tick) begin
                    if (r_s_cnt == 5'(SB_TICK-1)) begin
                        w_state_n = IDLE;
                        w_done_n  = 1'b1;
                        w_dout_n  = r_shreg;
                        w_ferr_n  = ~w_rx_s;
`ifdef UART_RX_PARITY_EN
                        w_perr_n  = ^{r_shreg, r_par};
`endif
                    end else begin
                        w_s_cnt_n = r_s_cnt + 5'd1;
                    end
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    assign rx_if.rx_dout      = r_dout;
    assign rx_if.rx_done_tick = r_done;
    assign rx_if.frame_err    = r_ferr;
    assign rx_if.busy         = (r_state != IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err   = r_perr;
`else
    assign rx_if.parity_err   = 1'b0;
`endif

endmodule
